// File: rtl/gpu_blitter.sv
// gpu_blitter: second-generation rectangle blitter.
//   DRAW  : copies a (optionally mirrored) excerpt of an RGBA5551 image from
//           memory to the framebuffer write port, skipping transparent pixels
//           (bit 0 clear) and pixels that fall outside the framebuffer.
//   FILL  : writes a constant colour over a clipped rectangle.
//   CLEAR : FILL over the whole framebuffer.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   i_ctrl_*                command inputs, sampled on an accepted i_ctrl_start
//   o_ctrl_busy/o_ctrl_done command in progress / one-cycle completion pulse
//   o_mem_addr/o_mem_read   read request, i_mem_valid/i_mem_data response
//   o_fb_x/o_fb_y/o_fb_color/o_fb_write  registered framebuffer write port
module gpu_blitter #(
    parameter int FB_WIDTH  = 400,
    parameter int FB_HEIGHT = 240,
    parameter int ADDR_W    = 32,
    parameter int COORD_W   = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_ctrl_start,
    input  logic [1:0]                   i_ctrl_mode,
    input  logic                         i_ctrl_flip_x,
    input  logic                         i_ctrl_flip_y,
    input  logic [ADDR_W-1:0]            i_ctrl_address,
    input  logic [15:0]                  i_ctrl_address_x,
    input  logic [15:0]                  i_ctrl_address_y,
    input  logic [15:0]                  i_ctrl_image_width,
    input  logic [COORD_W-1:0]           i_ctrl_width,
    input  logic [COORD_W-1:0]           i_ctrl_height,
    input  logic [COORD_W-1:0]           i_ctrl_x,
    input  logic [COORD_W-1:0]           i_ctrl_y,
    input  logic [15:0]                  i_ctrl_color,
    output logic                         o_ctrl_busy,
    output logic                         o_ctrl_done,
    output logic [ADDR_W-1:0]            o_mem_addr,
    output logic                         o_mem_read,
    input  logic                         i_mem_valid,
    input  logic [15:0]                  i_mem_data,
    output logic [$clog2(FB_WIDTH)-1:0]  o_fb_x,
    output logic [$clog2(FB_HEIGHT)-1:0] o_fb_y,
    output logic [15:0]                  o_fb_color,
    output logic                         o_fb_write
);

    localparam int XW  = $clog2(FB_WIDTH);
    localparam int YW  = $clog2(FB_HEIGHT);
    localparam int CW1 = COORD_W + 1;

    localparam logic [1:0] MODE_DRAW  = 2'd0;
    localparam logic [1:0] MODE_FILL  = 2'd1;
    localparam logic [1:0] MODE_CLEAR = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_WAIT    = 3'd2,
        S_FILLPIX = 3'd3,
        S_FINISH  = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next_state;

    // Latched command
    logic                  r_flip_x;
    logic                  r_flip_y;
    logic [ADDR_W-1:0]     r_base;
    logic [15:0]           r_ax;
    logic [15:0]           r_ay;
    logic [15:0]           r_stride;
    logic [COORD_W-1:0]    r_w;
    logic [COORD_W-1:0]    r_h;
    logic [COORD_W-1:0]    r_x;
    logic [COORD_W-1:0]    r_y;
    logic [15:0]           r_color;

    // Traversal counters: r_i column, r_j row
    logic [COORD_W-1:0]    r_i;
    logic [COORD_W-1:0]    r_j;

    // Registered outputs
    logic                  r_busy;
    logic                  r_done;
    logic                  r_fb_write;
    logic [XW-1:0]         r_fb_x;
    logic [YW-1:0]         r_fb_y;
    logic [15:0]           r_fb_color;

    // Combinational helpers
    logic                  w_accept;
    logic [COORD_W-1:0]    w_start_w;
    logic [COORD_W-1:0]    w_start_h;
    logic [COORD_W-1:0]    w_start_x;
    logic [COORD_W-1:0]    w_start_y;
    logic                  w_start_empty;
    logic [COORD_W:0]      w_sx;
    logic [COORD_W:0]      w_sy;
    logic                  w_inb;
    logic                  w_last;
    logic [COORD_W-1:0]    w_w_m1;
    logic [COORD_W-1:0]    w_h_m1;
    logic [COORD_W-1:0]    w_scol;
    logic [COORD_W-1:0]    w_srow;
    logic [ADDR_W-1:0]     w_addr;
    logic                  w_mem_read;
    logic                  w_adv;
    logic                  w_pix_we;
    logic [15:0]           w_pix_color;

    assign w_accept = (r_state == S_IDLE) && i_ctrl_start;

    // Effective rectangle of an incoming command (CLEAR covers the whole framebuffer)
    always_comb begin
        w_start_w = i_ctrl_width;
        w_start_h = i_ctrl_height;
        w_start_x = i_ctrl_x;
        w_start_y = i_ctrl_y;
        if (i_ctrl_mode == MODE_CLEAR) begin
            w_start_w = COORD_W'(FB_WIDTH);
            w_start_h = COORD_W'(FB_HEIGHT);
            w_start_x = '0;
            w_start_y = '0;
        end else begin
            w_start_w = i_ctrl_width;
            w_start_h = i_ctrl_height;
            w_start_x = i_ctrl_x;
            w_start_y = i_ctrl_y;
        end
        w_start_empty = (w_start_w == '0) || (w_start_h == '0) || (i_ctrl_mode == 2'd3);
    end

    // Destination position of the current pixel, clipping test and source address
    always_comb begin
        // One extra bit keeps the sign of x + i so negative positions clip correctly
        w_sx   = {r_x[COORD_W-1], r_x} + {1'b0, r_i};
        w_sy   = {r_y[COORD_W-1], r_y} + {1'b0, r_j};
        w_inb  = !w_sx[COORD_W] && (w_sx < CW1'(FB_WIDTH)) &&
                 !w_sy[COORD_W] && (w_sy < CW1'(FB_HEIGHT));
        w_w_m1 = r_w - COORD_W'(1);
        w_h_m1 = r_h - COORD_W'(1);
        w_last = (r_i == w_w_m1) && (r_j == w_h_m1);
        if (r_flip_x) begin
            w_scol = w_w_m1 - r_i;
        end else begin
            w_scol = r_i;
        end
        if (r_flip_y) begin
            w_srow = w_h_m1 - r_j;
        end else begin
            w_srow = r_j;
        end
        w_addr = r_base + (ADDR_W'(r_ay) + ADDR_W'(w_srow)) * ADDR_W'(r_stride)
               + ADDR_W'(r_ax) + ADDR_W'(w_scol);
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (!i_ctrl_start) begin
                    w_next_state = S_IDLE;
                end else if (w_start_empty) begin
                    w_next_state = S_FINISH;
                end else if (i_ctrl_mode == MODE_DRAW) begin
                    w_next_state = S_REQ;
                end else begin
                    w_next_state = S_FILLPIX;
                end
            end
            S_REQ: begin
                if (w_inb) begin
                    w_next_state = S_WAIT;
                end else if (w_last) begin
                    w_next_state = S_FINISH;
                end else begin
                    w_next_state = S_REQ;
                end
            end
            S_WAIT: begin
                if (!i_mem_valid) begin
                    w_next_state = S_WAIT;
                end else if (w_last) begin
                    w_next_state = S_FINISH;
                end else begin
                    w_next_state = S_REQ;
                end
            end
            S_FILLPIX: begin
                if (w_last) begin
                    w_next_state = S_FINISH;
                end else begin
                    w_next_state = S_FILLPIX;
                end
            end
            S_FINISH: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // FSM output decode: read request, counter advance and pixel write enable
    always_comb begin
        w_mem_read  = 1'b0;
        w_adv       = 1'b0;
        w_pix_we    = 1'b0;
        w_pix_color = r_color;
        case (r_state)
            S_REQ: begin
                w_mem_read = w_inb;
                w_adv      = !w_inb;
            end
            S_WAIT: begin
                w_adv       = i_mem_valid;
                w_pix_we    = i_mem_valid && i_mem_data[0];
                w_pix_color = i_mem_data;
            end
            S_FILLPIX: begin
                w_adv    = 1'b1;
                w_pix_we = w_inb;
            end
            default: begin
                w_mem_read  = 1'b0;
                w_adv       = 1'b0;
                w_pix_we    = 1'b0;
                w_pix_color = r_color;
            end
        endcase
    end

    // Command latch and row-major traversal counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flip_x <= 1'b0;
            r_flip_y <= 1'b0;
            r_base   <= '0;
            r_ax     <= 16'd0;
            r_ay     <= 16'd0;
            r_stride <= 16'd0;
            r_w      <= '0;
            r_h      <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_color  <= 16'd0;
            r_i      <= '0;
            r_j      <= '0;
        end else if (w_accept) begin
            r_flip_x <= i_ctrl_flip_x;
            r_flip_y <= i_ctrl_flip_y;
            r_base   <= i_ctrl_address;
            r_ax     <= i_ctrl_address_x;
            r_ay     <= i_ctrl_address_y;
            r_stride <= i_ctrl_image_width;
            r_w      <= w_start_w;
            r_h      <= w_start_h;
            r_x      <= w_start_x;
            r_y      <= w_start_y;
            r_color  <= i_ctrl_color;
            r_i      <= '0;
            r_j      <= '0;
        end else if (w_adv) begin
            if (r_i == w_w_m1) begin
                r_i <= '0;
                r_j <= r_j + COORD_W'(1);
            end else begin
                r_i <= r_i + COORD_W'(1);
            end
        end
    end

    // Registered status and framebuffer outputs; pixel fields hold when not writing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_fb_write <= 1'b0;
            r_fb_x     <= '0;
            r_fb_y     <= '0;
            r_fb_color <= 16'd0;
        end else begin
            r_busy     <= (w_next_state != S_IDLE);
            r_done     <= (r_state == S_FINISH);
            r_fb_write <= w_pix_we;
            if (w_pix_we) begin
                r_fb_x     <= w_sx[XW-1:0];
                r_fb_y     <= w_sy[YW-1:0];
                r_fb_color <= w_pix_color;
            end
        end
    end

    assign o_ctrl_busy = r_busy;
    assign o_ctrl_done = r_done;
    assign o_mem_read  = w_mem_read;
    assign o_mem_addr  = w_mem_read ? w_addr : '0;
    assign o_fb_write  = r_fb_write;
    assign o_fb_x      = r_fb_x;
    assign o_fb_y      = r_fb_y;
    assign o_fb_color  = r_fb_color;

endmodule

// File: tb/tb_gpu_blitter.sv
// Self-checking bench for gpu_blitter with a reduced 40x24 framebuffer.
// A behavioural model builds the expected read-address and pixel-write lists
// and busy length of each command; a per-cycle compare process consumes them.
module tb_gpu_blitter;

    localparam int FBW = 40;
    localparam int FBH = 24;
    localparam int AW  = 32;
    localparam int CW  = 16;
    localparam int XW  = $clog2(FBW);
    localparam int YW  = $clog2(FBH);

    logic            clk = 1'b0;
    logic            rst_n;
    logic            ctrl_start;
    logic [1:0]      ctrl_mode;
    logic            ctrl_flip_x, ctrl_flip_y;
    logic [AW-1:0]   ctrl_address;
    logic [15:0]     ctrl_address_x, ctrl_address_y, ctrl_image_width;
    logic [CW-1:0]   ctrl_width, ctrl_height, ctrl_x, ctrl_y;
    logic [15:0]     ctrl_color;
    logic            ctrl_busy, ctrl_done;
    logic [AW-1:0]   mem_addr;
    logic            mem_read;
    logic            mem_valid = 1'b0;
    logic [15:0]     mem_data = 16'd0;
    logic [XW-1:0]   fb_x;
    logic [YW-1:0]   fb_y;
    logic [15:0]     fb_color;
    logic            fb_write;

    always #5 clk = ~clk;

    gpu_blitter #(.FB_WIDTH(FBW), .FB_HEIGHT(FBH), .ADDR_W(AW), .COORD_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_ctrl_start(ctrl_start), .i_ctrl_mode(ctrl_mode),
        .i_ctrl_flip_x(ctrl_flip_x), .i_ctrl_flip_y(ctrl_flip_y),
        .i_ctrl_address(ctrl_address), .i_ctrl_address_x(ctrl_address_x),
        .i_ctrl_address_y(ctrl_address_y), .i_ctrl_image_width(ctrl_image_width),
        .i_ctrl_width(ctrl_width), .i_ctrl_height(ctrl_height),
        .i_ctrl_x(ctrl_x), .i_ctrl_y(ctrl_y), .i_ctrl_color(ctrl_color),
        .o_ctrl_busy(ctrl_busy), .o_ctrl_done(ctrl_done),
        .o_mem_addr(mem_addr), .o_mem_read(mem_read),
        .i_mem_valid(mem_valid), .i_mem_data(mem_data),
        .o_fb_x(fb_x), .o_fb_y(fb_y), .o_fb_color(fb_color), .o_fb_write(fb_write)
    );

    typedef struct {
        logic [1:0]  mode;
        bit          fx, fy;
        logic [31:0] addr;
        logic [15:0] ax, ay, iw, w, h, x, y, color;
        int          lat;
        int          dm;
    } cmd_t;

    typedef struct {
        int          x;
        int          y;
        logic [15:0] c;
    } pix_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] rd_q[$];
    pix_t        wr_q[$];
    int          exp_busy;
    int          busy_cnt = 0;
    int          done_cnt = 0;
    int          lat = 1;
    int          data_mode = 0;
    bit          noise = 1'b0;
    int          pend = 0;
    logic [31:0] pend_addr;
    int          last_x = 0, last_y = 0;
    logic [15:0] last_c = 16'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory contents: 0 = hashed (mixed opacity), 1 = hashed but opaque, 2 = constant 0x1234
    function automatic logic [15:0] mem_word(input logic [31:0] a);
        logic [15:0] h;
        h = (a[15:0] * 16'h9E37) ^ a[31:16] ^ 16'h5A5A;
        if (data_mode == 1) return h | 16'h0001;
        else if (data_mode == 2) return 16'h1234;
        else return h;
    endfunction

    // Memory responder: answers each read after `lat` cycles; optional junk valid in the request cycle
    always @(negedge clk) begin
        if (!rst_n) begin
            pend      = 0;
            mem_valid = 1'b0;
        end else begin
            mem_valid = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    mem_valid = 1'b1;
                    mem_data  = mem_word(pend_addr);
                end
            end
            if (mem_read) begin
                pend      = lat;
                pend_addr = mem_addr;
                if (noise) begin
                    mem_valid = 1'b1;
                    mem_data  = 16'($urandom);
                end
            end
        end
    end

    // Compare process: every cycle, reads and writes against the expected lists
    always @(negedge clk) begin
        pix_t p;
        if (!rst_n) begin
            rd_q.delete();
            wr_q.delete();
            last_x = 0;
            last_y = 0;
            last_c = 16'd0;
        end else begin
            if (mem_read) begin
                if (rd_q.size() == 0) check("rd_extra", 64'(mem_addr), 64'd0 - 64'd1);
                else check("rd_addr", 64'(mem_addr), 64'(rd_q.pop_front()));
            end
            if (fb_write) begin
                if (wr_q.size() == 0) begin
                    check("wr_extra", {fb_x, fb_y, fb_color}, 64'd0 - 64'd1);
                end else begin
                    p = wr_q.pop_front();
                    check("wr_pixel", {fb_x, fb_y, fb_color}, {XW'(p.x), YW'(p.y), p.c});
                    last_x = p.x;
                    last_y = p.y;
                    last_c = p.c;
                end
            end else begin
                check("fb_hold", {fb_x, fb_y, fb_color}, {XW'(last_x), YW'(last_y), last_c});
            end
            if (ctrl_busy) busy_cnt++;
            if (ctrl_done) done_cnt++;
        end
    end

    // Behavioural model: walk the rectangle and list what must happen
    task automatic build(input cmd_t c);
        int W, H, X, Y, sx, sy, scol, srow;
        logic [31:0] a;
        logic [15:0] d;
        lat       = c.lat;
        data_mode = c.dm;
        exp_busy  = 1;
        if (c.mode == 2'd2) begin
            W = FBW; H = FBH; X = 0; Y = 0;
        end else begin
            W = int'(c.w); H = int'(c.h);
            X = int'($signed(c.x)); Y = int'($signed(c.y));
        end
        if (c.mode == 2'd3 || W == 0 || H == 0) return;
        for (int j = 0; j < H; j++) begin
            for (int i = 0; i < W; i++) begin
                sx = X + i;
                sy = Y + j;
                if (sx >= 0 && sx < FBW && sy >= 0 && sy < FBH) begin
                    if (c.mode == 2'd0) begin
                        scol = c.fx ? W - 1 - i : i;
                        srow = c.fy ? H - 1 - j : j;
                        a = c.addr + (32'(c.ay) + 32'(srow)) * 32'(c.iw) + 32'(c.ax) + 32'(scol);
                        rd_q.push_back(a);
                        d = mem_word(a);
                        if (d[0]) wr_q.push_back('{sx, sy, d});
                        exp_busy += 1 + c.lat;
                    end else begin
                        wr_q.push_back('{sx, sy, c.color});
                        exp_busy += 1;
                    end
                end else begin
                    exp_busy += 1;
                end
            end
        end
    endtask

    task automatic drive(input cmd_t c);
        ctrl_mode = c.mode; ctrl_flip_x = c.fx; ctrl_flip_y = c.fy;
        ctrl_address = c.addr; ctrl_address_x = c.ax; ctrl_address_y = c.ay;
        ctrl_image_width = c.iw; ctrl_width = c.w; ctrl_height = c.h;
        ctrl_x = c.x; ctrl_y = c.y; ctrl_color = c.color;
    endtask

    task automatic scramble();
        ctrl_mode = 2'($urandom); ctrl_flip_x = 1'($urandom); ctrl_flip_y = 1'($urandom);
        ctrl_address = $urandom; ctrl_address_x = 16'($urandom); ctrl_address_y = 16'($urandom);
        ctrl_image_width = 16'($urandom); ctrl_width = 16'($urandom_range(1, 9));
        ctrl_height = 16'($urandom_range(1, 9)); ctrl_x = 16'($urandom_range(0, 9));
        ctrl_y = 16'($urandom_range(0, 9)); ctrl_color = 16'($urandom);
    endtask

    // Issue a built command; a second, ignored start is held during its first busy cycle
    task automatic exec(input cmd_t c);
        int b0, d0, k;
        noise = 1'($urandom_range(0, 1));
        b0 = busy_cnt;
        d0 = done_cnt;
        drive(c);
        ctrl_start = 1'b1;
        @(posedge clk); #1;
        scramble();
        @(posedge clk); #1;
        ctrl_start = 1'b0;
        k = 0;
        while (done_cnt == d0 && k < exp_busy + 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (done_cnt == d0) check("done_timeout", 64'd0, 64'd1);
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("done_once", 64'(done_cnt - d0), 64'd1);
        check("busy_cycles", 64'(busy_cnt - b0), 64'(exp_busy));
        check("rd_left", 64'(rd_q.size()), 64'd0);
        check("wr_left", 64'(wr_q.size()), 64'd0);
    endtask

    function automatic cmd_t mk(input logic [1:0] mode, input bit fx, input bit fy,
                                input logic [31:0] addr, input int ax, input int ay, input int iw,
                                input int w, input int h, input int x, input int y,
                                input logic [15:0] color, input int l, input int dm);
        cmd_t c;
        c.mode = mode; c.fx = fx; c.fy = fy; c.addr = addr;
        c.ax = 16'(ax); c.ay = 16'(ay); c.iw = 16'(iw); c.w = 16'(w); c.h = 16'(h);
        c.x = 16'(x); c.y = 16'(y); c.color = color; c.lat = l; c.dm = dm;
        return c;
    endfunction

    initial begin
        cmd_t c;
        int d0;
        rst_n = 1'b0;
        ctrl_start = 1'b0;
        scramble();
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("reset_outputs", {ctrl_busy, ctrl_done, mem_read, fb_write, fb_x, fb_y, fb_color}, 64'd0);
        check("reset_mem_addr", 64'(mem_addr), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // DRAW 2x2 at (10,5), latency 3, opaque
        c = mk(2'd0, 0, 0, 32'h1000, 1, 0, 8, 2, 2, 10, 5, 16'h0, 3, 1);
        build(c);
        check("model_rd0", 64'(rd_q[0]), 64'h1001);
        check("model_rd1", 64'(rd_q[1]), 64'h1002);
        check("model_rd2", 64'(rd_q[2]), 64'h1009);
        check("model_rd3", 64'(rd_q[3]), 64'h100A);
        check("model_wr3", {32'(wr_q[3].x), 32'(wr_q[3].y)}, {32'd11, 32'd6});
        check("model_busy", 64'(exp_busy), 64'd17);
        exec(c);

        // Same DRAW mirrored both ways
        c = mk(2'd0, 1, 1, 32'h1000, 1, 0, 8, 2, 2, 10, 5, 16'h0, 3, 1);
        build(c);
        check("model_flip_first", 64'(rd_q[0]), 64'h100A);
        check("model_flip_last", 64'(rd_q[3]), 64'h1001);
        exec(c);

        // DRAW 4x1 partly left of the framebuffer
        c = mk(2'd0, 0, 0, 32'h2000, 0, 3, 16, 4, 1, -2, 7, 16'h0, 2, 1);
        build(c);
        check("model_clip_reads", 64'(rd_q.size()), 64'd2);
        check("model_clip_x0", 64'(wr_q[0].x), 64'd0);
        exec(c);

        // Fully transparent image
        c = mk(2'd0, 0, 0, 32'h3000, 0, 0, 8, 3, 2, 4, 4, 16'h0, 1, 2);
        build(c);
        check("model_transparent", 64'(wr_q.size()), 64'd0);
        exec(c);

        // FILL clipped at the bottom-right corner
        c = mk(2'd1, 0, 0, 32'h0, 0, 0, 0, 3, 2, FBW - 2, FBH - 1, 16'hF801, 1, 0);
        build(c);
        check("model_fill_count", 64'(wr_q.size()), 64'd2);
        check("model_fill_x1", 64'(wr_q[1].x), 64'(FBW - 1));
        exec(c);

        // CLEAR ignores the rectangle inputs
        c = mk(2'd2, 0, 0, 32'h0, 0, 0, 0, 0, 0, -5, 9, 16'h7BDF, 1, 0);
        build(c);
        check("model_clear_count", 64'(wr_q.size()), 64'(FBW * FBH));
        exec(c);

        // Zero width and reserved mode
        c = mk(2'd0, 0, 0, 32'h4000, 0, 0, 8, 0, 3, 1, 1, 16'h0, 1, 0);
        build(c);
        check("model_zero_busy", 64'(exp_busy), 64'd1);
        exec(c);
        c = mk(2'd3, 0, 0, 32'h4000, 0, 0, 8, 3, 3, 1, 1, 16'h0, 1, 0);
        build(c);
        exec(c);

        // Randomized DRAW/FILL commands around the framebuffer edges
        for (int n = 0; n < 30; n++) begin
            c.mode  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 1));
            c.fx    = 1'($urandom_range(0, 1));
            c.fy    = 1'($urandom_range(0, 1));
            c.addr  = $urandom;
            c.ax    = 16'($urandom_range(0, 50));
            c.ay    = 16'($urandom_range(0, 50));
            c.iw    = 16'($urandom_range(1, 100));
            c.w     = 16'($urandom_range(0, 6));
            c.h     = 16'($urandom_range(0, 5));
            c.x     = 16'($urandom_range(0, FBW + 16)) - 16'd8;
            c.y     = 16'($urandom_range(0, FBH + 16)) - 16'd8;
            c.color = 16'($urandom);
            c.lat   = $urandom_range(1, 4);
            c.dm    = 0;
            build(c);
            exec(c);
        end

        // Reset in the middle of a DRAW aborts it
        c = mk(2'd0, 0, 0, 32'h5000, 0, 0, 8, 4, 4, 2, 2, 16'h0, 3, 1);
        build(c);
        drive(c);
        ctrl_start = 1'b1;
        @(posedge clk); #1;
        ctrl_start = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("abort_outputs", {ctrl_busy, ctrl_done, mem_read, fb_write, fb_x, fb_y, fb_color}, 64'd0);
        check("abort_mem_addr", 64'(mem_addr), 64'd0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        d0 = done_cnt;
        repeat (30) begin
            @(posedge clk); #1;
        end
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);
        check("abort_idle", {ctrl_busy, mem_read, fb_write}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
